// File: rtl/lfsr_noise_mixer.sv
// Two-stage valid/ready stage that mixes offset-binary LFSR noise, scaled by a
// power-of-two gain, into signed voice samples with saturation and a clip counter.
module lfsr_noise_mixer #(
    parameter int DW = 16,
    parameter int NW = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_sample,
    input  logic        [NW-1:0] noise,
    input  logic        [1:0]    mode,
    input  logic        [3:0]    gain_shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_sample,
    output logic                 out_sat,
    output logic        [CW-1:0] sat_count,
    input  logic                 clear_count
);

    // Headroom for a full-scale sample plus noise shifted by up to 15 bits.
    localparam int W = DW + 16;

    localparam logic signed [W-1:0] MAX_W = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W = {{(W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_MIX    = 2'b01,
        MODE_NOISE  = 2'b10,
        MODE_MUTE   = 2'b11
    } mode_e;

    // Returns {clipped, value} with the value limited to the DW-bit range.
    function automatic logic [DW:0] sat_dw(input logic signed [W-1:0] v);
        logic [DW:0] r;
        if (v > MAX_W)
            r = {1'b1, MAX_W[DW-1:0]};
        else if (v < MIN_W)
            r = {1'b1, MIN_W[DW-1:0]};
        else
            r = {1'b0, v[DW-1:0]};
        return r;
    endfunction

    logic                 vld_p1;
    logic                 vld_p2;
    logic signed [DW-1:0] sample_p1;
    logic        [NW-1:0] noise_p1;
    mode_e                mode_p1;
    logic        [3:0]    shift_p1;

    logic                 adv1;
    logic                 adv2;
    logic signed [NW-1:0] noise_s_p1;
    logic signed [W-1:0]  scaled_p1;
    logic signed [W-1:0]  mix_p1;
    logic        [DW:0]   mix_sat_p1;
    logic        [DW:0]   scaled_sat_p1;
    logic signed [DW-1:0] res_p1;
    logic                 sat_p1;
    logic                 cnt_inc;

    assign adv2      = !vld_p2 || out_ready;
    assign adv1      = !vld_p1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_p2;

    // ---- S1: capture sample, noise and controls together on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (adv1)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            sample_p1 <= in_sample;
            noise_p1  <= noise;
            mode_p1   <= mode_e'(mode);
            shift_p1  <= gain_shift;
        end
    end

    // Offset-binary noise becomes two's complement by flipping the MSB.
    assign noise_s_p1    = {~noise_p1[NW-1], noise_p1[NW-2:0]};
    assign scaled_p1     = {{(W-NW){noise_s_p1[NW-1]}}, noise_s_p1} << shift_p1;
    assign mix_p1        = {{(W-DW){sample_p1[DW-1]}}, sample_p1} + scaled_p1;
    assign mix_sat_p1    = sat_dw(mix_p1);
    assign scaled_sat_p1 = sat_dw(scaled_p1);

    always_comb begin
        res_p1 = sample_p1;
        sat_p1 = 1'b0;
        case (mode_p1)
            MODE_BYPASS: begin
                res_p1 = sample_p1;
                sat_p1 = 1'b0;
            end
            MODE_MIX: begin
                res_p1 = mix_sat_p1[DW-1:0];
                sat_p1 = mix_sat_p1[DW];
            end
            MODE_NOISE: begin
                res_p1 = scaled_sat_p1[DW-1:0];
                sat_p1 = scaled_sat_p1[DW];
            end
            MODE_MUTE: begin
                res_p1 = '0;
                sat_p1 = 1'b0;
            end
            default: begin
                res_p1 = '0;
                sat_p1 = 1'b0;
            end
        endcase
    end

    // ---- S2: output register, held while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2     <= 1'b0;
            out_sample <= '0;
            out_sat    <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_sample <= res_p1;
                out_sat    <= sat_p1;
            end
        end
    end

    assign cnt_inc = adv2 && vld_p1 && sat_p1;

    // A clear coinciding with a clip leaves that clip counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_count <= '0;
        else if (clear_count)
            sat_count <= cnt_inc ? {{(CW-1){1'b0}}, 1'b1} : '0;
        else if (cnt_inc && (sat_count != {CW{1'b1}}))
            sat_count <= sat_count + 1'b1;
    end

endmodule

// File: doc/lfsr_noise_mixer.md
Name: lfsr_noise_mixer

Overview:
- Pipelined audio-path stage directly downstream of the LFSR noise generator.
- Takes the generator's free-running N-bit noise word and mixes it into a stream of signed voice samples, using a valid/ready handshake on both sides.
- Noise is scaled by a programmable power-of-two gain and the result saturates to the sample width.
- Feeds the downstream audio/level-detect path and counts saturation events.

Parameters:
DW, 16, sample width (signed two's complement)
NW, 8, noise word width; must satisfy NW <= DW; matches generator width
CW, 8, saturation event counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  stage can accept a sample this cycle
in_sample  in  DW  signed input sample
noise  in  NW  LFSR output, sampled on input acceptance
mode  in  2  00 bypass, 01 mix, 10 noise-only, 11 mute
gain_shift  in  4  noise left-shift amount, 0..15
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out_sample  out  DW  signed result
out_sat  out  1  result for the current out_sample was clipped
sat_count  out  CW  saturating count of clipped samples
clear_count  in  1  synchronous clear of sat_count

Behaviour:
- Reset: clocking is on clk; reset is asynchronous and active-high.
  - Clears s1_valid, s2_valid, out_sample, out_sat and sat_count to 0.
  - in_ready is 1 after reset.
  - Asserting reset mid-stream discards all in-flight samples; nothing is emitted for them.
- Pipeline: two register stages (S1, S2); S2 drives the outputs.
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1. This is a combinational path from out_ready, which is permitted.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Latency is 2 cycles from input transfer to out_valid when not stalled.
  - Full throughput is 1 sample/cycle.
- S1 capture on input transfer: in_sample, noise, mode and gain_shift are captured together.
  - Changes to mode or gain_shift affect only samples accepted afterwards.
  - The noise port is ignored except on acceptance.
- S1 computation (registered into S2 when adv2):
  - noise_s = {~noise[NW-1], noise[NW-2:0]}, i.e. offset binary to signed. Range -2^(NW-1)..2^(NW-1)-1.
  - Intermediate width W = DW+16.
  - scaled = sext(noise_s, W) << gain_shift.
  - mix = sext(in_sample, W) + scaled.
  - Saturate to DW bits:
    - greater than 2^(DW-1)-1 gives 0x7FFF (for DW=16);
    - less than -2^(DW-1) gives 0x8000;
    - sat = 1 when clipped.
  - Per mode:
    - bypass: out = in_sample, sat = 0.
    - mix: out = sat(mix).
    - noise-only: out = sat(scaled).
    - mute: out = 0, sat = 0.
- Stall:
  - While out_valid & !out_ready, out_sample and out_sat hold stable.
  - While stalled, S1 holds if occupied.
  - No sample is dropped, duplicated or reordered.
  - At most 2 samples are in flight.
- sat_count:
  - On a cycle where an S1 to S2 transfer carries sat = 1, increments by 1.
  - Sticks at 2^CW-1 and does not wrap.
  - clear_count alone sets it to 0.
  - clear_count together with an increment in the same cycle sets it to 1.
- out_sat is payload: it is valid only when out_valid = 1, and is 0 after reset.

Test Plan:
1. Bypass: mode=00, in_sample=0x1234, noise=0x5A, out_ready=1 -> out_valid rises exactly 2 cycles later with out_sample=0x1234 and out_sat=0.
2. Mix: mode=01, in_sample=0x0100, noise=0xFF (+127), gain_shift=2 -> out_sample=0x02FC, out_sat=0. Then noise=0x80 (0) -> out_sample=0x0100.
3. Saturation:
   - mode=01, in_sample=0x7FF0, noise=0xFF, gain_shift=4 -> out_sample=0x7FFF, out_sat=1, sat_count=1.
   - in_sample=0x8010, noise=0x00 (-128), gain_shift=4 -> out_sample=0x8000, sat_count=2.
   - mode=10, noise=0xFF, gain_shift=15 -> 0x7FFF, sat_count=3.
4. Backpressure: stream samples 1,2,3,4 with in_valid=1 while out_ready=0 for 5 cycles -> only 1 and 2 are accepted and in_ready=0 afterwards; out_sample holds at 1. Then out_ready=1 -> outputs 1,2,3,4 appear in order on consecutive cycles with no gaps or duplicates.
5. Counter: CW=2, force 5 clipped samples -> sat_count reads 1,2,3,3,3. Then clear_count pulsed on the same cycle as a clipped sample -> sat_count=1. clear_count alone -> 0.
6. Reset mid-stream: with 2 samples in flight, pulse reset asynchronously between clock edges -> out_valid=0, out_sample=0, sat_count=0 and in_ready=1 immediately. No stale sample is emitted after release.
